// File: rtl/kamikaze_hazard_ctrl.sv
// kamikaze_hazard_ctrl
//   Pipeline control for the kamikaze core. Produces fetch/decode/execute
//   stall, flush and bubble controls for three cases: load-use hazards that
//   decode forwarding cannot cover, the decode flush after an execute
//   redirect, and holding the pipeline while a multi-cycle op runs.
//
//   Optional feature macro: KAMIKAZE_HAZARD_MC_WAIT_EN
//     defined   -> MC_WAIT state, with mc_start_i/mc_done_i honoured
//     undefined -> no MC_WAIT, ex_stall_o tied to 0, mc_* inputs ignored
module kamikaze_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2  // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_we_i,
  input  logic        ex_is_load_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_redirect_pc_i,
  input  logic        mc_start_i,
  input  logic        mc_done_i,
  output logic        if_stall_o,
  output logic        id_stall_o,
  output logic        id_flush_o,
  output logic        ex_bubble_o,
  output logic        ex_stall_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_redirect_target_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;

  // A single-cycle flush never needs the FLUSH state; the redirect cycle
  // itself already supplies the one invalid decode cycle.
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam int         RELOAD_INT   = MULTI_FLUSH ? int'(FLUSH_CYCLES) - 2 : 0;
  localparam logic [3:0] FLUSH_RELOAD = 4'(RELOAD_INT);

  state_t      state, state_nxt;
  logic [3:0]  flush_cnt, flush_cnt_nxt;
  logic [31:0] stall_cycles;
  logic        hz;
  logic        redirect;

`ifdef KAMIKAZE_HAZARD_MC_WAIT_EN
  logic        mc_start;
  assign mc_start = ex_valid_i & mc_start_i;
`else
  // mc_* stay on the port list for a uniform pinout but drive nothing.
  logic unused_mc;
  assign unused_mc = mc_start_i ^ mc_done_i;
`endif

  assign redirect = ex_valid_i & ex_redirect_i;

  // Load in execute whose destination is a live source of the decode instruction.
  assign hz = id_valid_i & ex_valid_i & ex_we_i & ex_is_load_i & (ex_rd_i != 5'd0) &
              ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
               (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

  // Next-state and control outputs; priority is redirect > multi-cycle > load-use.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if chain can leave one unassigned and infer a latch.
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if_stall_o    = 1'b0;
    id_stall_o    = 1'b0;
    id_flush_o    = 1'b0;
    ex_bubble_o   = 1'b0;
    ex_stall_o    = 1'b0;
    pc_redirect_o = 1'b0;

    if (!rst_i) begin
      unique case (state)
        ST_RUN: begin
          if (redirect) begin
            pc_redirect_o = 1'b1;
            id_flush_o    = 1'b1;
            ex_bubble_o   = 1'b1;
            if (MULTI_FLUSH) begin
              state_nxt     = ST_FLUSH;
              flush_cnt_nxt = FLUSH_RELOAD;
            end
          end
`ifdef KAMIKAZE_HAZARD_MC_WAIT_EN
          else if (mc_start) begin
            // An op finishing in its first cycle costs nothing.
            if (!mc_done_i) begin
              if_stall_o = 1'b1;
              id_stall_o = 1'b1;
              ex_stall_o = 1'b1;
              state_nxt  = ST_MC_WAIT;
            end
          end
`endif
          else if (hz) begin
            if_stall_o  = 1'b1;
            id_stall_o  = 1'b1;
            ex_bubble_o = 1'b1;
          end
        end

        ST_FLUSH: begin
          id_flush_o  = 1'b1;
          ex_bubble_o = 1'b1;
          if (redirect) begin
            pc_redirect_o = 1'b1;
            flush_cnt_nxt = FLUSH_RELOAD;
          end else if (flush_cnt == 4'd0) begin
            state_nxt = ST_RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end

`ifdef KAMIKAZE_HAZARD_MC_WAIT_EN
        ST_MC_WAIT: begin
          // Redirects cannot occur while execute is busy; ignore them here.
          if (mc_done_i) begin
            state_nxt = ST_RUN;
          end else begin
            if_stall_o = 1'b1;
            id_stall_o = 1'b1;
            ex_stall_o = 1'b1;
          end
        end
`endif

        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign pc_redirect_target_o = pc_redirect_o ? ex_redirect_pc_i : 32'd0;
  assign state_o              = rst_i ? 2'd0 : state;
  assign stall_cycles_o       = rst_i ? 32'd0 : stall_cycles;

  // State, flush counter and saturating stall counter.
  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      state        <= ST_RUN;
      flush_cnt    <= 4'd0;
      stall_cycles <= 32'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (if_stall_o && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_kamikaze_hazard_ctrl.sv
// tb_kamikaze_hazard_ctrl
//   Directed scenarios followed by randomized traffic, all checked cycle by
//   cycle against a behavioural model that tracks "flush cycles left",
//   "multi-cycle op busy" and a stall tally.
module tb_kamikaze_hazard_ctrl;

  localparam int unsigned FC = 2;
`ifdef KAMIKAZE_HAZARD_MC_WAIT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_valid, ex_we, ex_is_load, ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        mc_start, mc_done;
  logic        if_stall, id_stall, id_flush, ex_bubble, ex_stall, pc_redirect;
  logic [31:0] pc_target, stall_cycles;
  logic [1:0]  state;

  kamikaze_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .id_valid_i          (id_valid),
    .id_rs1_i            (id_rs1),
    .id_rs2_i            (id_rs2),
    .id_uses_rs1_i       (id_uses_rs1),
    .id_uses_rs2_i       (id_uses_rs2),
    .ex_valid_i          (ex_valid),
    .ex_rd_i             (ex_rd),
    .ex_we_i             (ex_we),
    .ex_is_load_i        (ex_is_load),
    .ex_redirect_i       (ex_redirect),
    .ex_redirect_pc_i    (ex_redirect_pc),
    .mc_start_i          (mc_start),
    .mc_done_i           (mc_done),
    .if_stall_o          (if_stall),
    .id_stall_o          (id_stall),
    .id_flush_o          (id_flush),
    .ex_bubble_o         (ex_bubble),
    .ex_stall_o          (ex_stall),
    .pc_redirect_o       (pc_redirect),
    .pc_redirect_target_o(pc_target),
    .state_o             (state),
    .stall_cycles_o      (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    else
      n_passed++;
  endtask

  // Reference model state.
  int          flush_left = 0;   // flush cycles still to come after this one
  bit          mc_busy    = 1'b0;
  logic [31:0] m_stalls   = 32'd0;

  function automatic bit load_use();
    bit match1, match2;
    match1 = id_uses_rs1 && (id_rs1 == ex_rd);
    match2 = id_uses_rs2 && (id_rs2 == ex_rd);
    return id_valid && ex_valid && ex_we && ex_is_load && (ex_rd != 0) && (match1 || match2);
  endfunction

  task automatic set_idle();
    rst = 0; id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_valid = 0; ex_we = 0;
    ex_is_load = 0; ex_redirect = 0; ex_redirect_pc = 0;
    mc_start = 0; mc_done = 0;
  endtask

  // Called just after a falling edge with inputs driven: checks outputs,
  // advances the model, and waits for the next falling edge.
  task automatic step();
    bit e_ifs = 0, e_ids = 0, e_fl = 0, e_bub = 0, e_exs = 0, e_pcr = 0;
    logic [1:0]  e_state = 2'd0;
    logic [31:0] e_cnt = 32'd0;
    bit redir;
    #1;
    redir = ex_valid && ex_redirect;
    if (rst) begin
      flush_left = 0;
      mc_busy    = 1'b0;
      m_stalls   = 32'd0;
    end else begin
      e_cnt = m_stalls;
      if (flush_left > 0) begin
        e_state = 2'd1;
        e_fl = 1; e_bub = 1;
        if (redir) begin e_pcr = 1; flush_left = FC - 1; end
        else flush_left--;
      end else if (mc_busy) begin
        e_state = 2'd2;
        if (mc_done) mc_busy = 1'b0;
        else begin e_ifs = 1; e_ids = 1; e_exs = 1; end
      end else if (redir) begin
        e_pcr = 1; e_fl = 1; e_bub = 1;
        flush_left = FC - 1;
      end else if (MC_EN && ex_valid && mc_start) begin
        if (!mc_done) begin e_ifs = 1; e_ids = 1; e_exs = 1; mc_busy = 1'b1; end
      end else if (load_use()) begin
        e_ifs = 1; e_ids = 1; e_bub = 1;
      end
      if (e_ifs && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    end
    check("if_stall",  32'(if_stall),    32'(e_ifs));
    check("id_stall",  32'(id_stall),    32'(e_ids));
    check("id_flush",  32'(id_flush),    32'(e_fl));
    check("ex_bubble", 32'(ex_bubble),   32'(e_bub));
    check("ex_stall",  32'(ex_stall),    32'(e_exs));
    check("pc_redir",  32'(pc_redirect), 32'(e_pcr));
    check("pc_target", pc_target,        e_pcr ? ex_redirect_pc : 32'd0);
    check("state",     32'(state),       32'(e_state));
    check("stall_cnt", stall_cycles,     e_cnt);
    @(negedge clk);
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = rd;
    id_valid = 1; id_uses_rs2 = 1; id_rs2 = 5'd5; id_rs1 = 5'd7; id_uses_rs1 = 1;
  endtask

  logic [31:0] cnt_before;

  initial begin
    set_idle();
    rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;
    step();                                        // idle cycle after reset: all 0

    // Load-use on rs2=x5: one bubble, then clear once the load leaves.
    set_load_use(5'd5); step();
    set_idle(); ex_valid = 1; id_valid = 1; id_uses_rs2 = 1; id_rs2 = 5'd5; step();
    set_load_use(5'd0); id_rs2 = 5'd0; step();    // x0 never hazards
    set_idle(); step();

    // Redirect to 0x100: flush cycles 0-1, RUN in cycle 2.
    ex_valid = 1; ex_redirect = 1; ex_redirect_pc = 32'h0000_0100; step();
    set_idle(); step();
    step();
    check("run_after_flush", 32'(state), 32'd0);

    // Redirect beats a simultaneous load-use and multi-cycle start.
    set_load_use(5'd5); ex_redirect = 1; ex_redirect_pc = 32'hDEAD_BEE0; mc_start = 1; step();
    set_idle(); step();
    step();

    // Multi-cycle op: start cycle 0, done cycle 4 -> 4 stall cycles.
    cnt_before = stall_cycles;
    ex_valid = 1; mc_start = 1; step();
    set_idle(); step(); step(); step();
    mc_done = 1; step();
    set_idle(); step();
    check("mc_stall_cost", stall_cycles - cnt_before, MC_EN ? 32'd4 : 32'd0);

    // Reset pulsed in the second MC_WAIT cycle.
    ex_valid = 1; mc_start = 1; step();
    set_idle(); step();
    rst = 1; step();
    rst = 0; step();
    check("rst_clears_cnt", stall_cycles, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(63) == 0);
      id_valid       = ($urandom_range(3) != 0);
      id_rs1         = 5'($urandom_range(3));
      id_rs2         = 5'($urandom_range(3));
      id_uses_rs1    = $urandom_range(1) != 0;
      id_uses_rs2    = $urandom_range(1) != 0;
      ex_valid       = ($urandom_range(3) != 0);
      ex_rd          = 5'($urandom_range(3));
      ex_we          = ($urandom_range(3) != 0);
      ex_is_load     = $urandom_range(1) != 0;
      ex_redirect    = ($urandom_range(7) == 0);
      ex_redirect_pc = $urandom;
      mc_start       = ($urandom_range(7) == 0);
      mc_done        = ($urandom_range(2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/kamikaze_hazard_ctrl.md
# kamikaze_hazard_ctrl

Pipeline control unit for the kamikaze core. It sits beside the decode stage and generates the stall, flush and bubble controls for fetch, decode and execute. It detects load-use hazards that the decode-stage forwarding path cannot cover, sequences the flush after a branch or jump redirect from execute, and holds the pipeline while a multi-cycle execute operation is in flight.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles decode is flushed after a redirect (legal range 1..15)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-high
- id_valid_i  in  1  decode holds a valid instruction
- id_rs1_i / id_rs2_i  in  5  decode source register addresses
- id_uses_rs1_i / id_uses_rs2_i  in  1  decode instruction actually reads rs1 / rs2
- ex_valid_i  in  1  execute holds a valid instruction
- ex_rd_i  in  5  execute destination register
- ex_we_i  in  1  execute writes rd
- ex_is_load_i  in  1  execute instruction is a load
- ex_redirect_i  in  1  execute resolved a taken branch/jump or a mispredict
- ex_redirect_pc_i  in  32  target PC for the redirect
- mc_start_i  in  1  execute instruction is a multi-cycle op (first cycle)
- mc_done_i  in  1  multi-cycle op completes this cycle
- if_stall_o  out  1  hold the fetch PC and instruction
- id_stall_o  out  1  hold the decode output registers
- id_flush_o  out  1  force decode_valid to 0 at the next edge
- ex_bubble_o  out  1  insert a NOP into execute at the next edge
- ex_stall_o  out  1  hold the execute stage
- pc_redirect_o  out  1  load the fetch PC from pc_redirect_target_o
- pc_redirect_target_o  out  32  redirect target
- state_o  out  2  current state: 0 RUN, 1 FLUSH, 2 MC_WAIT
- stall_cycles_o  out  32  performance counter of cycles with if_stall_o=1, saturating

## Operation
- Registered state: state, flush_cnt[3:0], stall_cycles.
- All control outputs are combinational from state and inputs. All are 0 while rst_i=1.
- Load-use hazard term:
  - hz = id_valid_i & ex_valid_i & ex_we_i & ex_is_load_i & (ex_rd_i≠0) & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i))
- Priority within a cycle: redirect > multi-cycle start > load-use.

RUN:
- ex_valid_i & ex_redirect_i:
  - pc_redirect_o=1 and pc_redirect_target_o=ex_redirect_pc_i in the same cycle.
  - id_flush_o=1, ex_bubble_o=1.
  - If FLUSH_CYCLES>1: next state FLUSH, flush_cnt=FLUSH_CYCLES-2. Otherwise stay in RUN.
- Else ex_valid_i & mc_start_i:
  - if_stall_o=id_stall_o=ex_stall_o=1.
  - Next state MC_WAIT, unless mc_done_i is also 1, in which case stay in RUN with no stall that cycle.
- Else hz:
  - if_stall_o=id_stall_o=ex_bubble_o=1 for exactly this cycle.
  - No state change; the hazard clears when the load leaves execute.

FLUSH:
- id_flush_o=1 and ex_bubble_o=1 every cycle.
- flush_cnt==0: next state RUN. Otherwise flush_cnt decrements.
- A new ex_redirect_i & ex_valid_i reissues pc_redirect_o and reloads flush_cnt=FLUSH_CYCLES-2.

MC_WAIT:
- if_stall_o=id_stall_o=ex_stall_o=1 every cycle.
- On mc_done_i=1: all stalls drop in that same cycle and the next state is RUN.
- ex_redirect_i is ignored.

Other rules:
- pc_redirect_target_o=ex_redirect_pc_i whenever pc_redirect_o=1, otherwise 0.
- stall_cycles increments every cycle with if_stall_o=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset: state=RUN, flush_cnt=0, stall_cycles=0. All outputs read 0 during reset and in the first cycle after it when the inputs are idle.
- Reset asserted mid-FLUSH or mid-MC_WAIT: the next edge forces RUN and the counters clear, with no residual stall.
- Redirect-to-fetch latency is 0 cycles (combinational).
- Decode is invalid for FLUSH_CYCLES consecutive cycles, counting the redirect cycle.
- Load-use costs exactly 1 bubble cycle.
- Multi-cycle op of N cycles (mc_done_i in its Nth cycle) costs N-1 stall cycles.

## Configuration
- KAMIKAZE_HAZARD_MC_WAIT_EN defined: MC_WAIT state and the mc_start_i/mc_done_i behaviour are built as above.
- Not defined:
  - MC_WAIT logic is not built and ex_stall_o is tied to 0.
  - mc_start_i and mc_done_i remain ports but are ignored.
  - state_o never reads 2.

## Test plan
- Load-use: load x5 in EX, decode uses rs2=x5 with id_uses_rs2_i=1 -> one cycle of if_stall_o=id_stall_o=ex_bubble_o=1, then 0. Same case with ex_rd_i=0 -> no stall.
- Redirect, FLUSH_CYCLES=2, ex_redirect_pc_i=0x0000_0100 -> pc_redirect_o=1 with target 0x100 in cycle 0; id_flush_o=1 in cycles 0-1; state_o returns to 0 in cycle 2.
- Redirect coinciding with a load-use hazard and mc_start_i -> redirect wins: no stall, state_o=1 next cycle.
- Multi-cycle op (macro defined): mc_start_i in cycle 0, mc_done_i in cycle 4 -> stalls in cycles 0-3, none in cycle 4, stall_cycles_o=4.
- rst_i pulsed in the second MC_WAIT cycle -> all outputs 0, state_o=0, stall_cycles_o=0 after the edge.
- Macro undefined, mc_start_i=1 -> ex_stall_o stays 0 and state_o stays 0.
